// File: rtl/sid_i2s_out.sv
// SID audio output stage: per-channel boxcar average, round/saturate to 16 bits,
// then serialise as a standard I2S stream (lrck low = left, one-bit data delay).
module sid_i2s_out #(
   parameter int unsigned BCLK_DIV = 10,
   parameter int unsigned AVG_LOG2 = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ce_1m,
   input  logic signed [17:0] audio_l,
   input  logic signed [17:0] audio_r,
   input  logic               mute,
   output logic               i2s_bclk,
   output logic               i2s_lrck,
   output logic               i2s_data,
   output logic signed [15:0] pcm_l,
   output logic signed [15:0] pcm_r,
   output logic               frame_strobe
);

   localparam int unsigned Depth = 1 << AVG_LOG2;
   localparam int unsigned SumW  = 18 + AVG_LOG2;

   logic signed [17:0]     buf_l_q [Depth];
   logic signed [17:0]     buf_r_q [Depth];
   logic signed [SumW-1:0] sum_l_q;
   logic signed [SumW-1:0] sum_r_q;
   logic [AVG_LOG2-1:0]    ptr_q;

   logic [7:0]  div_q;
   logic [4:0]  bit_q;
   logic [4:0]  bit_d;
   // Holds the 31 bits still to be sent; the first bit goes straight to i2s_data at load.
   logic [30:0] shift_q;

   logic               bclk_tc;
   logic               bclk_fall;
   logic signed [15:0] word_l;
   logic signed [15:0] word_r;

   // avg = floor(sum / depth); word = floor((avg + 2) / 4), clamped to 16 bits.
   function automatic logic signed [15:0] sat_word(input logic signed [SumW-1:0] sum);
      logic signed [17:0] avg;
      logic signed [18:0] rnd;
      logic signed [18:0] w;
      avg = 18'(sum >>> AVG_LOG2);
      rnd = {avg[17], avg} + 19'd2;
      w   = rnd >>> 2;
      if (w > 19'sd32767) begin
         sat_word = 16'sh7fff;
      end else if (w < -19'sd32768) begin
         sat_word = 16'sh8000;
      end else begin
         sat_word = w[15:0];
      end
   endfunction

   assign bclk_tc   = (div_q == 8'(BCLK_DIV - 1));
   assign bclk_fall = bclk_tc & i2s_bclk;
   assign bit_d     = bit_q + 5'd1;

   // Words to load this cycle, taken from the registered (pre-update) sums.
   always_comb begin
      word_l = '0;
      word_r = '0;
      if (!mute) begin
         word_l = sat_word(sum_l_q);
         word_r = sat_word(sum_r_q);
      end
   end

   // Moving-average buffers and running sums, advanced on each sample strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_l_q <= '{default: '0};
         buf_r_q <= '{default: '0};
         sum_l_q <= '0;
         sum_r_q <= '0;
         ptr_q   <= '0;
      end else if (ce_1m) begin
         sum_l_q        <= sum_l_q + SumW'(audio_l) - SumW'(buf_l_q[ptr_q]);
         sum_r_q        <= sum_r_q + SumW'(audio_r) - SumW'(buf_r_q[ptr_q]);
         buf_l_q[ptr_q] <= audio_l;
         buf_r_q[ptr_q] <= audio_r;
         ptr_q          <= ptr_q + AVG_LOG2'(1);
      end
   end

   // Bit-clock divider, bit counter, serialiser and PCM word latch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         i2s_bclk     <= 1'b0;
         i2s_lrck     <= 1'b0;
         i2s_data     <= 1'b0;
         pcm_l        <= '0;
         pcm_r        <= '0;
         frame_strobe <= 1'b0;
      end else begin
         frame_strobe <= 1'b0;
         if (bclk_tc) begin
            div_q    <= '0;
            i2s_bclk <= ~i2s_bclk;
         end else begin
            div_q <= div_q + 8'd1;
         end
         if (bclk_fall) begin
            bit_q    <= bit_d;
            i2s_lrck <= bit_d[4];
            if (bit_d == 5'd1) begin
               shift_q      <= {word_l[14:0], word_r};
               i2s_data     <= word_l[15];
               pcm_l        <= word_l;
               pcm_r        <= word_r;
               frame_strobe <= 1'b1;
            end else begin
               shift_q  <= {shift_q[29:0], 1'b0};
               i2s_data <= shift_q[30];
            end
         end
      end
   end

endmodule
